// File: rtl/sram_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : sram_uart_transmitter
// Purpose  : Reads a range of SRAM words and sends each one as two 8N1 UART
//            bytes, high byte first, back to back with no idle bits.
// Revision : 1.0
// ============================================================================
module sram_uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned        CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    // Read data is valid on the third edge after the address register loads.
    localparam logic [CNT_W-1:0]   FETCH_LAST = CNT_W'(2);

    typedef enum logic [2:0] {
        S_TX_IDLE  = 3'd0,
        S_TX_FETCH = 3'd1,
        S_TX_HI    = 3'd2,
        S_TX_LO    = 3'd3,
        S_TX_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    logic [17:0]       addr_q;
    logic [17:0]       remain_q;
    logic [15:0]       word_q;
    logic [15:0]       next_q;
    logic [7:0]        shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [3:0]        bit_idx_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic              w_bit_end;

    assign w_bit_end    = (bit_cnt_q == BIT_LAST);
    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign UART_TX_O    = tx_q;
    assign Busy         = busy_q;
    assign Done         = done_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_TX_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            word_q    <= '0;
            next_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_TX_IDLE: begin
                    if (Start) begin
                        if (Word_count != 18'd0) begin
                            addr_q    <= Base_address;
                            remain_q  <= Word_count;
                            busy_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= S_TX_FETCH;
                        end else begin
                            state_q <= S_TX_DONE;
                        end
                    end
                end

                S_TX_FETCH: begin
                    if (bit_cnt_q == FETCH_LAST) begin
                        word_q    <= SRAM_read_data;
                        shift_q   <= SRAM_read_data[15:8];
                        tx_q      <= 1'b0;
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_TX_HI;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end

                S_TX_HI, S_TX_LO: begin
                    // Prefetched word arrives during the low byte's start bit.
                    if (state_q == S_TX_LO && bit_idx_q == 4'd0 && bit_cnt_q == FETCH_LAST) begin
                        next_q <= SRAM_read_data;
                    end
                    if (!w_bit_end) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q != 4'd9) begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            if (bit_idx_q == 4'd8) begin
                                tx_q <= 1'b1;
                            end else begin
                                tx_q    <= shift_q[0];
                                shift_q <= {1'b0, shift_q[7:1]};
                            end
                        end else if (state_q == S_TX_HI) begin
                            shift_q   <= word_q[7:0];
                            tx_q      <= 1'b0;
                            bit_idx_q <= '0;
                            remain_q  <= remain_q - 18'd1;
                            if (remain_q != 18'd1) begin
                                addr_q <= addr_q + 18'd1;
                            end
                            state_q <= S_TX_LO;
                        end else if (remain_q != 18'd0) begin
                            word_q    <= next_q;
                            shift_q   <= next_q[15:8];
                            tx_q      <= 1'b0;
                            bit_idx_q <= '0;
                            state_q   <= S_TX_HI;
                        end else begin
                            bit_idx_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_TX_DONE;
                        end
                    end
                end

                S_TX_DONE: begin
                    // A normal finish arrives with Done already raised; a zero-length one raises it here.
                    if (done_q) begin
                        state_q <= S_TX_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end

                default: state_q <= S_TX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_uart_transmitter.sv
`default_nettype none
// Bench for sram_uart_transmitter: expected frames, Done pulses and address
// changes are queued at stimulus time and checked by an independent monitor.
module tb_sram_uart_transmitter;

    localparam int C = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [17:0] Base_address;
    logic [17:0] Word_count;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic        SRAM_we_n;
    logic        UART_TX_O;
    logic        Busy;
    logic        Done;

    sram_uart_transmitter #(.CLKS_PER_BIT(C)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .Base_address   (Base_address),
        .Word_count     (Word_count),
        .SRAM_address   (SRAM_address),
        .SRAM_read_data (SRAM_read_data),
        .SRAM_we_n      (SRAM_we_n),
        .UART_TX_O      (UART_TX_O),
        .Busy           (Busy),
        .Done           (Done)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // SRAM controller model: read data valid two edges after the address.
    logic [15:0] mem [0:262143];
    logic [17:0] sram_a1;
    always @(posedge Clock) begin
        sram_a1        <= SRAM_address;
        SRAM_read_data <= mem[sram_a1];
    end

    typedef struct { logic [7:0] data; int cyc; } frame_t;
    typedef struct { logic [17:0] addr; int cyc; } addr_t;

    frame_t      exp_frames[$];
    int          exp_done[$];
    addr_t       exp_addr[$];
    logic [17:0] model_addr;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic [17:0] base, input logic [17:0] cnt, input bit poke);
        int          e0;
        int          ws;
        int          total;
        logic [17:0] a;
        frame_t      f;
        addr_t       ea;
        @(negedge Clock);
        Start        = 1'b1;
        Base_address = base;
        Word_count   = cnt;
        e0           = cyc + 1;
        if (cnt == 18'd0) begin
            exp_done.push_back(e0 + 1);
            total = 4;
        end else begin
            for (int k = 0; k < int'(cnt); k++) begin
                a  = base + 18'(k);
                ws = e0 + 3 + k * 20 * C;
                if (k == 0) begin
                    if (a != model_addr) begin
                        ea.addr = a; ea.cyc = e0; exp_addr.push_back(ea);
                    end
                end else begin
                    ea.addr = a; ea.cyc = ws - 10 * C; exp_addr.push_back(ea);
                end
                model_addr = a;
                f.data = mem[a][15:8]; f.cyc = ws;          exp_frames.push_back(f);
                f.data = mem[a][7:0];  f.cyc = ws + 10 * C; exp_frames.push_back(f);
            end
            exp_done.push_back(e0 + 3 + int'(cnt) * 20 * C);
            total = 5 + int'(cnt) * 20 * C;
        end
        @(negedge Clock);
        Start = 1'b0;
        chk("busy_after_start", {31'd0, Busy}, {31'd0, cnt != 18'd0});
        for (int i = 1; i < total; i++) begin
            @(negedge Clock);
            Start = 1'b0;
            if (cnt == 18'd0) chk("busy_zero_len", {31'd0, Busy}, 32'd0);
            if (poke && i == total / 2 + 1) chk("busy_after_ignored_start", {31'd0, Busy}, 32'd1);
            if (poke && i == total / 2) begin
                Start        = 1'b1;
                Base_address = 18'($urandom);
                Word_count   = 18'($urandom_range(1, 5));
            end
        end
        chk("busy_end", {31'd0, Busy}, 32'd0);
        chk("line_idle_end", {31'd0, UART_TX_O}, 32'd1);
    endtask

    task automatic fill(input logic [17:0] base, input int n);
        for (int k = 0; k < n; k++) mem[base + 18'(k)] = 16'($urandom);
    endtask

    // Monitor: decodes the serial line and watches Done and SRAM_address.
    initial begin : monitor
        int          fpos;
        int          fstart;
        logic [9:0]  fbits;
        bit          glitch;
        logic [17:0] prev_addr;
        frame_t      f;
        addr_t       ea;
        fpos      = -1;
        fstart    = 0;
        fbits     = '0;
        glitch    = 1'b0;
        prev_addr = '0;
        forever begin
            @(posedge Clock);
            #1;
            if (Reset) begin
                fpos      = -1;
                prev_addr = SRAM_address;
            end else begin
                if (SRAM_address !== prev_addr) begin
                    if (exp_addr.size() == 0) begin
                        chk("addr_unexpected_change", {14'd0, SRAM_address}, {14'd0, prev_addr});
                    end else begin
                        ea = exp_addr.pop_front();
                        chk("addr_value", {14'd0, SRAM_address}, {14'd0, ea.addr});
                        chk("addr_cycle", cyc, ea.cyc);
                    end
                    prev_addr = SRAM_address;
                end
                if (Done === 1'b1) begin
                    chk("busy_at_done", {31'd0, Busy}, 32'd0);
                    if (exp_done.size() == 0) chk("done_unexpected", {31'd0, Done}, 32'd0);
                    else chk("done_cycle", cyc, exp_done.pop_front());
                end
                if (fpos < 0 && UART_TX_O === 1'b0) begin
                    fpos   = 0;
                    fstart = cyc;
                    fbits  = '0;
                    glitch = 1'b0;
                end
                if (fpos >= 0) begin
                    if (fpos % C == 0) fbits[fpos / C] = UART_TX_O;
                    else if (UART_TX_O !== fbits[fpos / C]) glitch = 1'b1;
                    if (fpos == 10 * C - 1) begin
                        chk("bit_hold", {31'd0, glitch}, 32'd0);
                        if (exp_frames.size() == 0) begin
                            chk("frame_unexpected", {22'd0, fbits}, 32'h3FF);
                        end else begin
                            f = exp_frames.pop_front();
                            chk("frame_bits", {22'd0, fbits}, {22'd0, 1'b1, f.data, 1'b0});
                            chk("frame_start", fstart, f.cyc);
                        end
                        fpos = -1;
                    end else begin
                        fpos++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [17:0] b;
        int          n;
        addr_t       ea;
        Reset        = 1'b1;
        Start        = 1'b0;
        Base_address = '0;
        Word_count   = '0;
        model_addr   = '0;
        repeat (3) @(negedge Clock);
        chk("rst_line", {31'd0, UART_TX_O}, 32'd1);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_addr", {14'd0, SRAM_address}, 32'd0);
        chk("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
        Reset = 1'b0;
        repeat (10) begin
            @(negedge Clock);
            chk("idle_line", {31'd0, UART_TX_O}, 32'd1);
        end

        mem[18'h00010] = 16'hA55A;
        send(18'h00010, 18'd1, 1'b0);

        b = 18'($urandom);
        mem[b] = 16'h0102; mem[b + 18'd1] = 16'h0304; mem[b + 18'd2] = 16'h0506;
        send(b, 18'd3, 1'b0);

        send(18'($urandom), 18'd0, 1'b0);
        chk("addr_hold_zero_len", {14'd0, SRAM_address}, {14'd0, model_addr});

        mem[18'h3FFFF] = 16'hBEEF; mem[18'h00000] = 16'h1234;
        send(18'h3FFFF, 18'd2, 1'b1);

        for (int t = 0; t < 6; t++) begin
            b = 18'($urandom);
            n = $urandom_range(1, 4);
            fill(b, n);
            send(b, 18'(n), $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of the first high-byte frame.
        b = 18'($urandom);
        fill(b, 2);
        @(negedge Clock);
        Start = 1'b1; Base_address = b; Word_count = 18'd2;
        if (b != model_addr) begin
            ea.addr = b; ea.cyc = cyc + 1; exp_addr.push_back(ea);
        end
        @(negedge Clock);
        Start = 1'b0;
        repeat (18) @(negedge Clock);
        chk("busy_mid_frame", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        chk("midrst_line", {31'd0, UART_TX_O}, 32'd1);
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_done", {31'd0, Done}, 32'd0);
        chk("midrst_addr", {14'd0, SRAM_address}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        exp_frames.delete();
        exp_done.delete();
        exp_addr.delete();
        model_addr = '0;
        repeat (60) begin
            @(negedge Clock);
            chk("post_rst_line", {31'd0, UART_TX_O}, 32'd1);
        end

        b = 18'($urandom);
        fill(b, 1);
        send(b, 18'd1, 1'b0);

        repeat (5) @(negedge Clock);
        chk("frames_outstanding", exp_frames.size(), 32'd0);
        chk("done_outstanding", exp_done.size(), 32'd0);
        chk("addr_outstanding", exp_addr.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
